// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and pipeline_ctrl (slave):
// stage hazard/memory/branch status in, freeze/flush/bubble/stall/redirect controls out.
interface pipeline_ctrl_if #(
    parameter int REG_W = 4
);
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             twoSrc;
    logic             idValid;
    logic             exeWbEn;
    logic [REG_W-1:0] exeDest;
    logic             exeMemRead;
    logic             memWbEn;
    logic [REG_W-1:0] memDest;
    logic             memReq;
    logic             branchTakenIn;
    logic [31:0]      branchAddrIn;
    logic             freeze;
    logic             flush;
    logic             idExBubble;
    logic             memStall;
    logic             branchTaken;
    logic [31:0]      branchAddr;

    modport master (
        output src1, src2, twoSrc, idValid, exeWbEn, exeDest, exeMemRead,
               memWbEn, memDest, memReq, branchTakenIn, branchAddrIn,
        input  freeze, flush, idExBubble, memStall, branchTaken, branchAddr
    );

    modport slave (
        input  src1, src2, twoSrc, idValid, exeWbEn, exeDest, exeMemRead,
               memWbEn, memDest, memReq, branchTakenIn, branchAddrIn,
        output freeze, flush, idExBubble, memStall, branchTaken, branchAddr
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control: RAW hazard detection, data-memory wait-state sequencing and stall-safe
// branch redirect. Define FORWARDING_EN when a forwarding unit exists (only load-use stalls).
module pipeline_ctrl #(
    parameter int MEM_WAIT_CYCLES = 4,
    parameter int REG_W           = 4
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave pif
);
    localparam int CNT_W       = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES) : 1;
    localparam int CNT_LOAD    = (MEM_WAIT_CYCLES > 1) ? (MEM_WAIT_CYCLES - 2) : 0;
    localparam bit MULTI_CYCLE = (MEM_WAIT_CYCLES > 1);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             mem_stall_s;
    logic             hazard_s;
    logic             branch_go_s;
    logic [REG_W-1:0] src1_s;
    logic [REG_W-1:0] src2_s;
    logic [REG_W-1:0] exe_dest_s;
    logic [REG_W-1:0] mem_dest_s;
    logic             unused_ok_s;

    assign src1_s     = pif.src1;
    assign src2_s     = pif.src2;
    assign exe_dest_s = pif.exeDest;
    assign mem_dest_s = pif.memDest;

`ifdef FORWARDING_EN
    assign unused_ok_s = ^{pif.exeWbEn, pif.memWbEn, mem_dest_s};

    // With forwarding only a load in EXE cannot supply its result in time
    always_comb begin
        hazard_s = pif.idValid & pif.exeMemRead &
                   ((exe_dest_s == src1_s) | (pif.twoSrc & (exe_dest_s == src2_s)));
    end
`else
    assign unused_ok_s = pif.exeMemRead;

    // Without forwarding any pending EXE/MEM write to a source register must stall ID
    always_comb begin
        hazard_s = pif.idValid &
                   ((pif.exeWbEn & (exe_dest_s == src1_s)) |
                    (pif.memWbEn & (mem_dest_s == src1_s)) |
                    (pif.twoSrc & ((pif.exeWbEn & (exe_dest_s == src2_s)) |
                                   (pif.memWbEn & (mem_dest_s == src2_s)))));
    end
`endif

    // Wait-state sequencing: the access cycle in RUN stalls, then WAIT counts down to release
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        mem_stall_s = 1'b0;
        case (state_r)
            RUN: begin
                if (pif.memReq && MULTI_CYCLE) begin
                    mem_stall_s = 1'b1;
                    state_nxt_s = WAIT;
                    cnt_nxt_s   = CNT_W'(CNT_LOAD);
                end else begin
                    mem_stall_s = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    mem_stall_s = 1'b1;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and wait counter registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Control outputs; a branch held in EXE during a stall issues on the release cycle
    always_comb begin
        branch_go_s = 1'b0;
        if (rst) begin
            pif.freeze      = 1'b0;
            pif.flush       = 1'b0;
            pif.idExBubble  = 1'b0;
            pif.memStall    = 1'b0;
            pif.branchTaken = 1'b0;
            pif.branchAddr  = 32'h0000_0000;
        end else begin
            branch_go_s     = pif.branchTakenIn & ~mem_stall_s;
            pif.freeze      = mem_stall_s | (hazard_s & ~branch_go_s);
            pif.flush       = branch_go_s;
            pif.idExBubble  = (hazard_s & ~mem_stall_s) | branch_go_s;
            pif.memStall    = mem_stall_s;
            pif.branchTaken = branch_go_s;
            pif.branchAddr  = pif.branchAddrIn;
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: a 4-cycle and a 1-cycle memory instance driven in parallel, compared
// every cycle against an access-window reference model plus directed scenario constants.
module tb_pipeline_ctrl;
    localparam int RW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [RW-1:0] src1, src2, exeDest, memDest;
    logic        twoSrc, idValid, exeWbEn, exeMemRead, memWbEn, memReq, branchTakenIn;
    logic [31:0] branchAddrIn;
    logic [1:0][36:0] obs;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint start [2] = '{-100, -100};
    int     mwc   [2] = '{4, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipeline_ctrl_if #(.REG_W(RW)) pif ();
        assign pif.src1          = src1;
        assign pif.src2          = src2;
        assign pif.twoSrc        = twoSrc;
        assign pif.idValid       = idValid;
        assign pif.exeWbEn       = exeWbEn;
        assign pif.exeDest       = exeDest;
        assign pif.exeMemRead    = exeMemRead;
        assign pif.memWbEn       = memWbEn;
        assign pif.memDest       = memDest;
        assign pif.memReq        = memReq;
        assign pif.branchTakenIn = branchTakenIn;
        assign pif.branchAddrIn  = branchAddrIn;
        pipeline_ctrl #(.MEM_WAIT_CYCLES(g == 0 ? 4 : 1), .REG_W(RW)) dut (
            .clk(clk), .rst(rst), .pif(pif)
        );
        assign obs[g] = {pif.freeze, pif.flush, pif.idExBubble, pif.memStall,
                         pif.branchTaken, pif.branchAddr};
    end

    // Reference: an access occupies mwc cycles from its start; all but the last stall.
    function automatic logic [36:0] model(int g);
        logic haz, stall, bt, frz, bub;
        longint rel;
        bit busy;
`ifdef FORWARDING_EN
        haz = idValid && exeMemRead && ((exeDest == src1) || (twoSrc && exeDest == src2));
`else
        haz = idValid && ((exeWbEn && exeDest == src1) || (memWbEn && memDest == src1) ||
              (twoSrc && ((exeWbEn && exeDest == src2) || (memWbEn && memDest == src2))));
`endif
        rel   = cyc - start[g];
        busy  = (rel >= 0) && (rel < mwc[g]);
        stall = busy ? (rel < mwc[g] - 1) : (memReq && mwc[g] > 1);
        bt    = branchTakenIn && !stall;
        frz   = stall || (haz && !bt);
        bub   = (haz && !stall) || bt;
        if (rst) return 37'h0;
        return {frz, bt, bub, stall, bt, branchAddrIn};
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            longint rel = cyc - start[g];
            bit busy = (rel >= 0) && (rel < mwc[g]);
            if (rst) start[g] = -100;
            else if (!busy && memReq && mwc[g] > 1) start[g] = cyc;
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        src1 = '0; src2 = '0; exeDest = '0; memDest = '0;
        twoSrc = 1'b0; idValid = 1'b0; exeWbEn = 1'b0; exeMemRead = 1'b0;
        memWbEn = 1'b0; memReq = 1'b0; branchTakenIn = 1'b0; branchAddrIn = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs();
        memReq = 1'b1; branchTakenIn = 1'b1; branchAddrIn = 32'h1234_5678;
        idValid = 1'b1; exeWbEn = 1'b1; exeMemRead = 1'b1; src1 = 4'd2; exeDest = 4'd2;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs[g] !== 37'h0) begin
                failures++; $display("FAIL reset_active dut%0d got=%h want=%h", g, obs[g], 37'h0);
            end
        end
        tick(); tick();
        rst = 1'b0; clear_inputs(); #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs[g] !== 37'h0) begin
                failures++; $display("FAIL reset_first_cycle dut%0d got=%h want=%h", g, obs[g], 37'h0);
            end
        end
        tick();
    endtask

    task automatic test_hazard();
        logic exp_bit;
        clear_inputs();
        idValid = 1'b1; src1 = 4'd3; exeWbEn = 1'b1; exeDest = 4'd3; #1;
`ifdef FORWARDING_EN
        exp_bit = 1'b0;
`else
        exp_bit = 1'b1;
`endif
        checks++;
        if (obs[0][36] !== exp_bit || obs[0][34] !== exp_bit) begin
            failures++;
            $display("FAIL hazard_exe_src1 freeze=%b bubble=%b want=%b", obs[0][36], obs[0][34], exp_bit);
        end
        tick();
        for (int p = 0; p < 6; p++) begin
            clear_inputs();
            idValid = 1'b1; twoSrc = p[0]; src1 = 4'd5; src2 = 4'd9;
            exeWbEn = p[1]; exeMemRead = p[2]; memWbEn = ~p[1];
            exeDest = (p < 3) ? 4'd9 : 4'd5; memDest = (p < 3) ? 4'd5 : 4'd9;
            #1;
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (obs[g] !== model(g)) begin
                    failures++; $display("FAIL hazard_pat%0d dut%0d got=%h want=%h", p, g, obs[g], model(g));
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_mem_pulse();
        int n4 = 0, n1 = 0;
        clear_inputs();
        for (int c = 0; c < 6; c++) begin
            memReq = (c == 0); #1;
            n4 += int'(obs[0][33]); n1 += int'(obs[1][33]);
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (obs[g] !== model(g)) begin
                    failures++; $display("FAIL mem_pulse c%0d dut%0d got=%h want=%h", c, g, obs[g], model(g));
                end
            end
            tick();
        end
        checks++;
        if (n4 !== 3 || n1 !== 0) begin
            failures++; $display("FAIL mem_pulse_len got=%0d/%0d want=3/0", n4, n1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat4, pat1;
        clear_inputs(); memReq = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1; pat4[7-c] = obs[0][33]; pat1[7-c] = obs[1][33];
            tick();
        end
        checks++;
        if (pat4 !== 8'b1110_1110 || pat1 !== 8'b0000_0000) begin
            failures++; $display("FAIL back_to_back got=%b/%b want=11101110/00000000", pat4, pat1);
        end
        clear_inputs(); tick(); tick(); tick(); tick();
    endtask

    task automatic test_branch_hazard();
        clear_inputs();
        idValid = 1'b1; src1 = 4'd7; exeWbEn = 1'b1; exeMemRead = 1'b1; exeDest = 4'd7;
        branchTakenIn = 1'b1; branchAddrIn = 32'h0000_0040; #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (obs[g] !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040}) begin
                failures++; $display("FAIL branch_over_hazard dut%0d got=%h want=%h", g, obs[g],
                                     {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0040});
            end
        end
        tick(); clear_inputs();
    endtask

    task automatic test_branch_stall();
        logic [3:0] bt4, bt1;
        clear_inputs();
        branchTakenIn = 1'b1; branchAddrIn = $urandom;
        for (int c = 0; c < 4; c++) begin
            memReq = (c == 0); #1;
            bt4[3-c] = obs[0][32]; bt1[3-c] = obs[1][32];
            checks++;
            if (obs[0] !== model(0)) begin
                failures++; $display("FAIL branch_stall c%0d got=%h want=%h", c, obs[0], model(0));
            end
            tick();
        end
        checks++;
        if (bt4 !== 4'b0001 || bt1 !== 4'b1111) begin
            failures++; $display("FAIL branch_release got=%b/%b want=0001/1111", bt4, bt1);
        end
        clear_inputs(); tick();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs(); memReq = 1'b1; tick();
        memReq = 1'b0; rst = 1'b1; #1;
        checks++;
        if (obs[0] !== 37'h0) begin
            failures++; $display("FAIL reset_in_wait got=%h want=%h", obs[0], 37'h0);
        end
        tick(); rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1; checks++;
            if (obs[0] !== 37'h0) begin
                failures++; $display("FAIL after_reset_in_wait c%0d got=%h want=%h", c, obs[0], 37'h0);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            src1 = RW'($urandom_range(0, 3)); src2 = RW'($urandom_range(0, 3));
            exeDest = RW'($urandom_range(0, 3)); memDest = RW'($urandom_range(0, 3));
            twoSrc = 1'($urandom); idValid = 1'($urandom); exeWbEn = 1'($urandom);
            exeMemRead = 1'($urandom); memWbEn = 1'($urandom);
            memReq = ($urandom_range(0, 2) == 0); branchTakenIn = ($urandom_range(0, 3) == 0);
            branchAddrIn = $urandom;
            #1;
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (obs[g] !== model(g)) begin
                    failures++; $display("FAIL random c%0d dut%0d got=%h want=%h", c, g, obs[g], model(g));
                end
            end
            tick();
        end
        rst = 1'b0; clear_inputs();
    endtask

    initial begin
        rst = 1'b1; clear_inputs();
        #1;
        test_reset();
        test_hazard();
        test_mem_pulse();
        test_back_to_back();
        test_branch_hazard();
        test_branch_stall();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control unit driving the freeze/flush/branch inputs of the fetch stage and IF/ID register, plus the ID/EX bubble and memory-stall controls of later stages. It detects RAW hazards between the ID-stage sources and the EXE/MEM destinations. It sequences multi-cycle data-memory accesses with a wait-state FSM and gates EXE-stage branch redirects so none is lost during a stall.

## Interface
- MEM_WAIT_CYCLES, 4, total cycles per data-memory access (>=1)
- REG_W, 4, register-address width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- src1  in  REG_W  ID-stage first source register
- src2  in  REG_W  ID-stage second source register
- twoSrc  in  1  ID instruction reads src2
- idValid  in  1  ID holds a real instruction
- exeWbEn  in  1  EXE instruction writes back
- exeDest  in  REG_W  EXE destination
- exeMemRead  in  1  EXE instruction is a load
- memWbEn  in  1  MEM instruction writes back
- memDest  in  REG_W  MEM destination
- memReq  in  1  MEM stage has a load/store
- branchTakenIn  in  1  EXE branch resolved taken
- branchAddrIn  in  32  EXE branch target
- freeze  out  1  hold PC and IF/ID
- flush  out  1  clear IF/ID
- idExBubble  out  1  load NOP into ID/EX
- memStall  out  1  hold ID/EX, EXE/MEM, MEM/WB
- branchTaken  out  1  redirect PC
- branchAddr  out  32  redirect target (equals branchAddrIn)

## Operation
- hazard = idValid & ((exeWbEn & exeDest==src1) | (memWbEn & memDest==src1) | twoSrc & ((exeWbEn & exeDest==src2) | (memWbEn & memDest==src2))).
- FSM states RUN, WAIT; down-counter cnt, width clog2(MEM_WAIT_CYCLES).
- RUN, memReq=1, MEM_WAIT_CYCLES>1: memStall=1; next WAIT, cnt<=MEM_WAIT_CYCLES-2.
- RUN, MEM_WAIT_CYCLES==1: memStall=0 always; state never leaves RUN.
- WAIT, cnt!=0: memStall=1, cnt decrements.
- WAIT, cnt==0: memStall=0 (access completes this cycle); next RUN.
- memReq high on the RUN cycle after WAIT starts a new access (back-to-back loads).
- branchTaken = flush = branchTakenIn & ~memStall. A branch arriving during a stall is held in EXE and issues on the release cycle.
- idExBubble = (hazard & ~memStall) | branchTaken.
- freeze = memStall | (hazard & ~branchTaken). A taken branch overrides a hazard freeze.
- All outputs are combinational from state and inputs. All are forced to 0 while rst=1.

## Timing
- Reset: state=RUN, cnt=0. Outputs 0 during reset and on the first cycle after, absent requests.
- Hazard freeze/bubble and branch redirect take effect in the same cycle (zero latency).
- Memory access: memStall high for exactly MEM_WAIT_CYCLES-1 consecutive cycles, starting in the memReq cycle.
- Reset mid-WAIT: next cycle state=RUN and memStall=0; the aborted access is not resumed.
- memReq dropping during WAIT is ignored; the count always completes.

## Configuration
- FORWARDING_EN defined: an EXE/MEM forwarding unit exists. The hazard term reduces to idValid & exeMemRead & (exeDest==src1 | twoSrc & exeDest==src2); MEM-stage matches and non-load EXE matches never freeze.
- Undefined: full hazard equation above.

## Test plan
- Reset mid-WAIT (cycle 2 of a 4-cycle access) -> state RUN, memStall=0, all outputs 0 next cycle.
- idValid=1, src1=3, exeWbEn=1, exeDest=3 -> freeze=1, idExBubble=1 the same cycle. With FORWARDING_EN and exeMemRead=0 -> both 0.
- MEM_WAIT_CYCLES=4, memReq pulse -> memStall=1 for exactly 3 cycles. With memReq held for 2 accesses -> 3 high, 1 low, 3 high.
- branchTakenIn=1, branchAddrIn=0x40 with a hazard active -> branchTaken=1, branchAddr=0x40, flush=1, idExBubble=1, freeze=0.
- branchTakenIn=1 during WAIT -> branchTaken=0 until the release cycle, then 1 for that cycle.
- MEM_WAIT_CYCLES=1, memReq=1 every cycle -> memStall never asserts.
